// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, fetch and sequencer signals around the shared RAM arbiter.
interface mem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [1:0]        d_type;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_flush;
    logic              i_done;
    logic [31:0]       i_rdata;
    logic [ADDR_W-1:0] i_pc;
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [1:0]        m_type;
    logic              m_done;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        output d_req, d_we, d_addr, d_wdata, d_type, i_req, i_addr, i_flush, m_done, m_rdata,
        input  d_done, d_rdata, i_done, i_rdata, i_pc, m_req, m_we, m_addr, m_wdata, m_type
    );

    modport slave (
        input  d_req, d_we, d_addr, d_wdata, d_type, i_req, i_addr, i_flush, m_done, m_rdata,
        output d_done, d_rdata, i_done, i_rdata, i_pc, m_req, m_we, m_addr, m_wdata, m_type
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM sequencer between data and fetch, data first with fetch anti-starvation.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input logic        clk,
    input logic        rst,
    mem_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, DRAIN} state_t;

    state_t        state, state_n;
    logic [SW-1:0] starve_cnt;
    logic          grant_d, grant_i, pick_i, arb_ok;

    // Arbitration waits out the done cycle so a still-held request is not re-issued.
    always_comb begin
        arb_ok  = state == IDLE && !bus.d_done && !bus.i_done;
        pick_i  = bus.i_req && !bus.i_flush && (!bus.d_req || starve_cnt == SW'(STARVE_MAX));
        grant_d = arb_ok && bus.d_req && !pick_i;
        grant_i = arb_ok && pick_i;
        state_n = state;
        case (state)
            IDLE:    state_n = grant_d ? BUSY_D : grant_i ? BUSY_I : IDLE;
            BUSY_D:  state_n = bus.m_done ? IDLE : BUSY_D;
            BUSY_I:  state_n = bus.m_done ? IDLE : bus.i_flush ? DRAIN : BUSY_I;
            default: state_n = bus.m_done ? IDLE : DRAIN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            bus.m_req   <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_addr  <= ADDR_W'(0);
            bus.m_wdata <= DATA_W'(0);
            bus.m_type  <= 2'b00;
            bus.d_done  <= 1'b0;
            bus.d_rdata <= DATA_W'(0);
            bus.i_done  <= 1'b0;
            bus.i_rdata <= 32'd0;
            bus.i_pc    <= ADDR_W'(0);
        end else begin
            state     <= state_n;
            bus.m_req <= grant_d || grant_i;
            if (grant_d || grant_i) begin
                bus.m_we    <= grant_d && bus.d_we;
                bus.m_addr  <= grant_d ? bus.d_addr : bus.i_addr;
                bus.m_wdata <= grant_d ? bus.d_wdata : DATA_W'(0);
                bus.m_type  <= grant_d ? bus.d_type : 2'b11;
            end
            if (grant_i || (grant_d && !bus.i_req))
                starve_cnt <= '0;
            else if (grant_d && starve_cnt != SW'(STARVE_MAX))
                starve_cnt <= starve_cnt + SW'(1);
            bus.d_done <= state == BUSY_D && bus.m_done;
            if (state == BUSY_D && bus.m_done && !bus.m_we)
                bus.d_rdata <= bus.m_rdata;
            // A flush coinciding with completion still discards the fetched word.
            bus.i_done <= state == BUSY_I && bus.m_done && !bus.i_flush;
            if (state == BUSY_I && bus.m_done && !bus.i_flush) begin
                bus.i_rdata <= bus.m_rdata[31:0];
                bus.i_pc    <= bus.m_addr;
            end
        end
    end
endmodule
